// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Streams a program into instruction memory from a byte channel.  Four
//   bytes are assembled big-endian into one 32-bit word, the word is written
//   with a single mem_we strobe, and the address advances until the latched
//   word count has been written.  cpu_hold keeps the processor stalled for
//   the whole load.
//
// Ports
//   clk, rst_n   : system clock, asynchronous active-low reset
//   start        : one-cycle load request (only looked at in IDLE)
//   word_count   : words to load, 0..2**ADDR_WIDTH (latched on start)
//   rx_data      : program byte
//   rx_valid     : rx_data valid
//   rx_ready     : loader takes a byte this cycle (RECV only)
//   mem_we       : instruction-memory write strobe
//   mem_addr     : instruction-memory word address
//   mem_wdata    : assembled instruction word
//   busy         : not IDLE
//   cpu_hold     : same as busy
//   done         : one-cycle pulse at the end of a load
//   err          : sticky, last start had an oversized word_count
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_WIDTH:0] cnt_lat;
    logic [1:0]          byte_cnt;
    logic                accept;
    logic                start_zero;
    logic                start_bad;
    logic                start_ok;
    logic                last_word;

    assign accept     = rx_valid && rx_ready;
    assign start_zero = start && (word_count == '0);
    assign start_bad  = start && (word_count > MAX_WORDS);
    assign start_ok   = start && !start_zero && !start_bad;
    // The address is compared one ahead so a full load ends at the top
    // address instead of wrapping back to 0.
    assign last_word  = ({1'b0, mem_addr} + (ADDR_WIDTH+1)'(1)) == cnt_lat;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok)        state_nxt = RECV;
                else if (start_zero) state_nxt = DONE;
            end
            RECV:    if (accept && byte_cnt == 2'd3) state_nxt = WRITE;
            WRITE:   state_nxt = last_word ? DONE : RECV;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded straight from the state register so reset
    // clears them without waiting for a clock.
    always_comb begin
        rx_ready = (state == RECV);
        mem_we   = (state == WRITE);
        done     = (state == DONE);
        busy     = (state != IDLE);
        cpu_hold = busy;
    end

    // Datapath: latched count, byte counter, address, word assembly, err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_lat   <= '0;
            byte_cnt  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_bad) begin
                        err <= 1'b1;
                    end else if (start) begin
                        err      <= 1'b0;
                        cnt_lat  <= word_count;
                        byte_cnt <= '0;
                        mem_addr <= '0;
                    end
                end
                RECV: begin
                    // Shifting in at the bottom leaves the first byte in
                    // [31:24] once all four have arrived; the 2-bit counter
                    // wraps back to 0 on the fourth byte.
                    if (accept) begin
                        mem_wdata <= {mem_wdata[23:0], rx_data};
                        byte_cnt  <= byte_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    if (!last_word) mem_addr <= mem_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, which sets the instruction-memory word-address width (MAX_WORDS = 2**ADDR_WIDTH).
REQ-002 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  rising-edge system clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have port start  in  1  — single-cycle request to begin a load; sampled only in IDLE.
REQ-004 SHALL have port word_count  in  ADDR_WIDTH+1  — number of 32-bit words to load; latched when start is accepted.
REQ-005 SHALL have port rx_data  in  8  — incoming program byte.
REQ-006 SHALL have port rx_valid  in  1  — rx_data is valid.
REQ-007 SHALL have port rx_ready  out  1  — loader accepts a byte this cycle.
REQ-008 SHALL have port mem_we  out  1  — instruction-memory write strobe.
REQ-009 SHALL have port mem_addr  out  ADDR_WIDTH  — instruction-memory word address.
REQ-010 SHALL have port mem_wdata  out  32  — assembled instruction word.
REQ-011 SHALL have port busy  out  1  — high in any state other than IDLE.
REQ-012 SHALL have port cpu_hold  out  1  — equals busy; stalls the processor PC while a load is in progress.
REQ-013 SHALL have port done  out  1  — single-cycle pulse when a load completes.
REQ-014 SHALL have port err  out  1  — sticky flag: the last start was rejected.

Function
REQ-015 SHALL implement four states: IDLE, RECV, WRITE, DONE.
REQ-016 In IDLE, start=1 with 1 <= word_count <= MAX_WORDS SHALL:
- latch word_count;
- clear the byte counter and mem_addr;
- clear err;
- enter RECV.
REQ-017 In IDLE, start=1 with word_count=0 SHALL go directly to DONE with no memory write, and SHALL clear err.
REQ-018 In IDLE, start=1 with word_count > MAX_WORDS SHALL set err, stay in IDLE, and leave busy low.
REQ-019 A byte SHALL be accepted only on a cycle with rx_valid=1 and rx_ready=1; rx_ready SHALL be 1 only in RECV.
REQ-020 Bytes SHALL assemble big-endian:
- 1st accepted byte -> mem_wdata[31:24];
- 2nd -> [23:16];
- 3rd -> [15:8];
- 4th -> [7:0].
REQ-021 Acceptance of the 4th byte SHALL move the FSM to WRITE; rx_ready SHALL be 0 in WRITE.
REQ-022 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_addr and mem_wdata stable during that cycle.
REQ-023 Write latency SHALL be 1 cycle: mem_we is high in the cycle immediately after the cycle in which the 4th byte is accepted.
REQ-024 After WRITE, if the words written equal the latched count, the FSM SHALL enter DONE; otherwise it SHALL increment mem_addr by 1 and return to RECV.
REQ-025 For a full load of MAX_WORDS words, the last write SHALL be at address MAX_WORDS-1, and mem_addr SHALL NOT wrap to 0 and write again.
REQ-026 In DONE, done SHALL be 1 for one cycle, and the FSM SHALL then return to IDLE.
REQ-027 start asserted while busy SHALL be ignored.
REQ-028 rx_valid asserted while rx_ready=0 SHALL NOT consume or shift data.
REQ-029 A gap in rx_valid during RECV SHALL hold the byte counter and the partial word indefinitely.
REQ-030 Minimum throughput SHALL be 5 cycles per word: 4 byte-accept cycles plus 1 WRITE cycle.

Reset
REQ-031 Asserting rst_n=0 at any time SHALL asynchronously force the following, including mid-load with no memory write issued after reset assertion:
- state=IDLE;
- rx_ready, mem_we, busy, cpu_hold, done, err = 0;
- mem_addr = 0, mem_wdata = 0;
- byte counter and latched count = 0.
REQ-032 After rst_n is released, the block SHALL remain in IDLE until a new start is accepted; a partial word in progress at reset SHALL be discarded.

Verification
REQ-033 Basic load: start with word_count=2, bytes 12 34 56 78 AB CD EF 01 sent back-to-back -> two mem_we pulses, writing addr0=0x12345678 and addr1=0xABCDEF01, then one done pulse; busy is high from the cycle after start until the done cycle.
REQ-034 Flow control: same load with rx_valid gaps of 3 cycles between bytes -> identical writes, with no byte accepted while rx_ready=0 (including during the WRITE cycles).
REQ-035 Bounds: start with word_count=0 -> done pulse with no mem_we; start with word_count=MAX_WORDS+1 -> err=1 and busy stays 0; a following valid start clears err.
REQ-036 Full memory: ADDR_WIDTH=2, word_count=4 -> writes at addresses 0,1,2,3 only, then done.
REQ-037 Reset mid-operation: assert rst_n=0 after the 2nd byte of word 1 -> all outputs 0 immediately; a new load of 1 word then writes addr0 correctly.
REQ-038 Ignored start: pulse start during RECV with a different word_count -> the original count is honoured.
